// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory data port among NumReq masters, one transaction in flight.
// Optional BUSY watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int DWidth        = 32,
    parameter int NumReq        = 2,
    parameter int TimeoutCycles = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        write_i,
    input  logic [NumReq*DWidth-1:0] addr_i,
    input  logic [NumReq*DWidth-1:0] wdata_i,
    output logic [NumReq-1:0]        ready_o,
    output logic [DWidth-1:0]        rdata_o,
    output logic                     err_o,
    output logic                     mem_req_o,
    output logic                     mem_write_o,
    output logic [DWidth-1:0]        mem_addr_o,
    output logic [DWidth-1:0]        mem_wdata_o,
    input  logic                     mem_ready_i,
    input  logic [DWidth-1:0]        mem_rdata_i
);
    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e                         state_q, state_d;
    logic [IdxW-1:0]                gnt_q, gnt_d, rr_ptr_q, rr_ptr_d, sel, gnt_nxt;
    logic                           mem_req_q, mem_req_d, mem_write_q, mem_write_d;
    logic [DWidth-1:0]              mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [DWidth-1:0]              rdata_q, rdata_d;
    logic [NumReq-1:0]              ready_q, ready_d;
    logic [NumReq-1:0][DWidth-1:0]  addr_arr, wdata_arr;
    logic                           timeout;

    assign addr_arr  = addr_i;
    assign wdata_arr = wdata_i;

    // Scan offsets high to low so the requester closest to rr_ptr wins.
    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                                input logic [IdxW-1:0]   ptr);
        logic [IdxW-1:0] pick;
        int              j;
        pick = '0;
        for (int i = NumReq - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NumReq) j = j - NumReq;
            if (req[j]) pick = IdxW'(j);
        end
        return pick;
    endfunction

    assign sel     = rr_pick(req_i, rr_ptr_q);
    assign gnt_nxt = (int'(gnt_q) == NumReq - 1) ? '0 : gnt_q + IdxW'(1);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    assign timeout = (state_q == BUSY) && (cnt_q == CntW'(TimeoutCycles - 1));
    // Counter is zero outside BUSY, so it restarts on every entry.
    assign cnt_d   = (state_q == BUSY) ? cnt_q + CntW'(1) : '0;
    assign err_d   = (state_q == BUSY) && !mem_ready_i && timeout;
    assign err_o   = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ready_d     = '0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d       = sel;
                    mem_req_d   = 1'b1;
                    mem_write_d = write_i[sel];
                    mem_addr_d  = addr_arr[sel];
                    mem_wdata_d = wdata_arr[sel];
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready_i || timeout) begin
                    ready_d[gnt_q] = 1'b1;
                    mem_req_d      = 1'b0;
                    rr_ptr_d       = gnt_nxt;
                    state_d        = RESP;
                    if (!mem_ready_i)      rdata_d = '0;
                    else if (!mem_write_q) rdata_d = mem_rdata_i;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            ready_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    assign ready_o     = ready_q;
    assign rdata_o     = rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_write_o = mem_write_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Round-robin arbiter that shares the single data port of the unified memory among `NumReq` bus masters, e.g. the RISC-V core data port and the MLP accelerator's weight/activation fetch engine.
- Only one transaction is in flight at a time. The selected request's command is registered and held on the memory port until the memory's `ready` pulse.
- The response is returned to the granted master as a one-cycle `ready` pulse.
- Sits between the masters and the memory's `dmem_*` interface, on the core clock.

## Interface
Parameters:
- `DWidth`, 32, address/data width.
- `NumReq`, 2, number of masters (2..8).
- `TimeoutCycles`, 64, watchdog limit in cycles. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_i` in NumReq: per-master request. Held high until that master's `ready_o` bit pulses.
- `write_i` in NumReq: per-master write flag.
- `addr_i` in NumReq*DWidth: packed byte addresses. Master k uses bits [k*DWidth +: DWidth].
- `wdata_i` in NumReq*DWidth: packed write data, same slicing as `addr_i`.
- `ready_o` out NumReq: one-hot completion pulse.
- `rdata_o` out DWidth: read data. Valid while any `ready_o` bit is high.
- `err_o` out 1: timeout flag. Qualified by `ready_o`.
- `mem_req_o`, `mem_write_o` out 1: command to memory.
- `mem_addr_o`, `mem_wdata_o` out DWidth: command to memory.
- `mem_ready_i` in 1: completion pulse from memory.
- `mem_rdata_i` in DWidth: read data from memory.

## Operation
State machine has three states: IDLE, BUSY, RESP.

IDLE:
- If any `req_i` bit is high, pick the first requesting index at or after `rr_ptr`, wrapping modulo NumReq.
- Register `mem_write_o`, `mem_addr_o` and `mem_wdata_o` from that master, set `mem_req_o`=1 and record the grant index `gnt`.
- Go to BUSY.

BUSY:
- `mem_req_o` and the command are held constant.
- Master inputs are ignored, including changes on the granted master's lines.
- On `mem_ready_i`=1:
  - Set `ready_o[gnt]`=1.
  - For a read, load `rdata_o` from `mem_rdata_i`. For a write, leave `rdata_o` unchanged.
  - Clear `mem_req_o`.
  - Set `rr_ptr` = (gnt+1) mod NumReq.
  - Go to RESP.

RESP:
- Clear `ready_o` and `err_o`, then go to IDLE.
- Re-arbitration happens in IDLE. This gives one turnaround cycle, so the memory always sees `mem_req_o` low for at least one cycle between transactions.

Boundary and other required behaviour:
- Simultaneous requests are served strictly round-robin. A continuously requesting master cannot starve another.
- A single requester is granted back-to-back.
- `mem_ready_i` seen in IDLE or RESP is ignored.
- A master that drops `req_i` while granted still receives its `ready_o` pulse.
- `rdata_o` holds its last value between responses.
- Reset asserted mid-transaction aborts immediately:
  - the state returns to IDLE;
  - no `ready_o` is issued;
  - the memory may still complete internally, but its pulse is ignored after reset.

## Timing
- Reset values: every output is 0, state is IDLE, `rr_ptr`=0, watchdog counter is 0.
- Cycle t: `req_i[k]` high in IDLE and k wins arbitration. At cycle t+1, `mem_req_o`=1.
- If `mem_ready_i` is high at cycle m, then at cycle m+1 `ready_o[k]`=1 with `rdata_o` valid. At cycle m+2, `ready_o`=0 and the state is IDLE.
- Arbiter overhead is 2 cycles plus memory latency. Next earliest grant is cycle m+2, so `mem_req_o` high again at m+3.
- The master must drop or change `req_i` in the cycle after it sees `ready_o`. A `req_i` still high in IDLE is treated as a new request.
- `ready_o` is always exactly one cycle wide and at most one bit is set.

## Configuration
Macro: `MEM_ARB_TIMEOUT_EN`.

Defined:
- A counter runs in BUSY; it clears on entry to BUSY.
- If it reaches `TimeoutCycles`-1 with no `mem_ready_i`, the arbiter:
  - pulses `ready_o[gnt]` with `err_o`=1 and `rdata_o`=0;
  - clears `mem_req_o`;
  - advances `rr_ptr`;
  - goes to RESP.
- If `mem_ready_i` arrives in the same cycle as the timeout, the normal response wins and `err_o`=0.

Undefined:
- No counter is built and `err_o` is tied to 0.
- BUSY waits indefinitely for `mem_ready_i`.

## Test plan
1. Reset, then master 0 reads address 0x100 and memory returns 0xDEADBEEF after 4 cycles. Expect `mem_req_o` one cycle after `req_i`, and `ready_o`=01 for exactly one cycle with `rdata_o`=0xDEADBEEF.
2. Master 1 writes 0xA5A5A5A5 to 0x200. Expect `mem_write_o`=1, `mem_addr_o`=0x200, `mem_wdata_o`=0xA5A5A5A5, and `ready_o`=10 for one cycle. `rdata_o` is unchanged.
3. Both masters hold `req_i` continuously for 6 transactions. Expect grants 0,1,0,1,0,1, with `mem_req_o` low for at least one cycle between transactions.
4. Assert `rst_ni` low mid-BUSY, then pulse `mem_ready_i` after release. Expect all outputs 0 asynchronously, no `ready_o` pulse, and the next grant goes to master 0.
5. With `MEM_ARB_TIMEOUT_EN` and TimeoutCycles=8, the memory never responds. Expect `ready_o[gnt]` with `err_o`=1 and `rdata_o`=0 after 8 BUSY cycles. Without the macro, expect no response and `err_o` stuck at 0.
